// File: rtl/truth_sweep_ctrl.sv
// Sweeps {A,B,C} through 0..7 across six logic units, captures their Y truth tables and flags units that disagree with the golden tables.
// Optional feature: define SWEEP_ERR_CNT_EN to add the err_cnt mismatch counter port.
module truth_sweep_ctrl #(
   parameter int unsigned     SETTLE_CYC = 2,
   parameter logic [7:0]      GOLD_T1    = 8'hE8,
   parameter logic [7:0]      GOLD_T2    = 8'h96
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [2:0]         abc,
   input  logic [5:0]         y_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [5:0]         fail_mask,
`ifdef SWEEP_ERR_CNT_EN
   output logic [5:0]         err_cnt,
`endif
   output logic [47:0]        tt_cap
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

   state_t      state;
   logic [2:0]  idx;
   logic [3:0]  cnt;
   logic [5:0]  mismatch;
   logic [2:0]  mis_cnt;
   logic [47:0] tt_next;

   // Per-unit comparison of the current sample against the golden tables
   always_comb begin
      mismatch = 6'd0;
      mis_cnt  = 3'd0;
      tt_next  = tt_cap;
      for (int i = 0; i < 6; i++) begin
         mismatch[i] = y_in[i] ^ ((i < 3) ? GOLD_T1[idx] : GOLD_T2[idx]);
         mis_cnt     = mis_cnt + {2'b00, mismatch[i]};
         tt_next[i*8 + int'(idx)] = y_in[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 3'd0;
         cnt       <= 4'd0;
         abc       <= 3'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= 6'd0;
         tt_cap    <= 48'd0;
`ifdef SWEEP_ERR_CNT_EN
         err_cnt   <= 6'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= SETTLE;
                  idx       <= 3'd0;
                  abc       <= 3'd0;
                  cnt       <= SETTLE_LOAD;
                  busy      <= 1'b1;
                  fail_mask <= 6'd0;
                  tt_cap    <= 48'd0;
`ifdef SWEEP_ERR_CNT_EN
                  err_cnt   <= 6'd0;
`endif
               end
            end
            SETTLE: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               tt_cap    <= tt_next;
               fail_mask <= fail_mask | mismatch;
`ifdef SWEEP_ERR_CNT_EN
               // At most 48 mismatches per sweep, so 6 bits never wrap
               err_cnt   <= err_cnt + {3'b000, mis_cnt};
`endif
               if (idx == 3'd7) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  abc   <= 3'd0;
               end else begin
                  state <= SETTLE;
                  idx   <= idx + 3'd1;
                  abc   <= idx + 3'd1;
                  cnt   <= SETTLE_LOAD;
               end
            end
            DONE: begin
               // fail_mask already holds the last sample's result here
               done  <= 1'b1;
               pass  <= (fail_mask == 6'd0);
               idx   <= 3'd0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Directed self-checking bench for truth_sweep_ctrl: good, stuck, inverted units, mid-sweep reset and start handling.
module tb_truth_sweep_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  abc;
   logic [5:0]  y_in;
   logic        busy;
   logic        done;
   logic        pass;
   logic [5:0]  fail_mask;
   logic [47:0] tt_cap;
`ifdef SWEEP_ERR_CNT_EN
   logic [5:0]  err_cnt;
`endif

   int cmp_count;
   int err_count;
   int mode;

   truth_sweep_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abc       (abc),
      .y_in      (y_in),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_mask (fail_mask),
`ifdef SWEEP_ERR_CNT_EN
      .err_cnt   (err_cnt),
`endif
      .tt_cap    (tt_cap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unit models: 0 = correct (majority / parity), 1 = unit 4 stuck at 0, 2 = all inverted
   always_comb begin
      logic [7:0] maj;
      logic [7:0] par;
      maj = 8'hE8;
      par = 8'h96;
      y_in = 6'd0;
      for (int i = 0; i < 6; i++) begin
         y_in[i] = (i < 3) ? maj[abc] : par[abc];
         if (mode == 1 && i == 4) y_in[i] = 1'b0;
         if (mode == 2) y_in[i] = ~y_in[i];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_count++;
      if (obs !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses start, optionally pokes start again mid-sweep, and returns cycles from accept edge to done
   task automatic applyStimulus(input int mode_sel, input bit poke_busy, output int latency);
      mode = mode_sel;
      latency = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (poke_busy && c == 5) start = 1'b1;
         if (poke_busy && c == 6) start = 1'b0;
         if (done) begin
            latency = c;
            break;
         end
      end
   endtask

   task automatic checkResults(input string tag, input logic [47:0] exp_tt, input logic [5:0] exp_fm,
                               input logic exp_pass, input int exp_err);
      checkOutput({tag, "_tt"}, 64'(tt_cap), 64'(exp_tt));
      checkOutput({tag, "_fm"}, 64'(fail_mask), 64'(exp_fm));
      checkOutput({tag, "_pass"}, 64'(pass), 64'(exp_pass));
`ifdef SWEEP_ERR_CNT_EN
      checkOutput({tag, "_err"}, 64'(err_cnt), 64'(exp_err));
`endif
   endtask

   initial begin
      int lat;
      int first_done;
      int second_done;
      logic prev_abc_zero;
      logic gap_ok;
      cmp_count = 0;
      err_count = 0;
      mode = 0;
      start = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_abc", 64'(abc), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkResults("rst", 48'd0, 6'd0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, 1'b0, lat);
      checkOutput("good_lat", 64'(lat), 64'd25);
      checkOutput("good_abc", 64'(abc), 64'd0);
      checkResults("good", 48'h969696E8E8E8, 6'h00, 1'b1, 0);
      @(posedge clk);
      #1 checkOutput("done_pulse_width", 64'(done), 64'd0);

      applyStimulus(1, 1'b0, lat);
      checkOutput("stuck_lat", 64'(lat), 64'd25);
      checkResults("stuck", 48'h960096E8E8E8, 6'b010000, 1'b0, 4);

      applyStimulus(2, 1'b0, lat);
      checkResults("inv", 48'h696969171717, 6'h3F, 1'b0, 48);

      // Mid-sweep reset once abc reaches 3
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (abc == 3'd3) begin
            lat = c;
            break;
         end
      end
      checkOutput("reach_idx3", 64'(lat > 0), 64'd1);
      checkOutput("busy_idx3", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_abc", 64'(abc), 64'd0);
      checkOutput("arst_busy", 64'(busy), 64'd0);
      checkResults("arst", 48'd0, 6'd0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 checkOutput("post_rst_idle_busy", 64'(busy), 64'd0);
      applyStimulus(0, 1'b0, lat);
      checkOutput("post_rst_lat", 64'(lat), 64'd25);
      checkResults("post_rst", 48'h969696E8E8E8, 6'h00, 1'b1, 0);

      // start poked while busy must not disturb the sweep
      applyStimulus(1, 1'b1, lat);
      checkOutput("poke_lat", 64'(lat), 64'd25);
      checkResults("poke", 48'h960096E8E8E8, 6'b010000, 1'b0, 4);

      // start held high: back-to-back sweeps
      mode = 0;
      first_done = -1;
      second_done = -1;
      gap_ok = 1'b1;
      prev_abc_zero = 1'b1;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (first_done < 0) begin
               first_done = c;
               if (!prev_abc_zero || abc != 3'd0) gap_ok = 1'b0;
            end else begin
               second_done = c;
               start = 1'b0;
               break;
            end
         end
         prev_abc_zero = (abc == 3'd0);
      end
      checkOutput("b2b_spacing", 64'(second_done - first_done), 64'd26);
      checkOutput("b2b_gap_abc", 64'(gap_ok), 64'd1);
      checkResults("b2b", 48'h969696E8E8E8, 6'h00, 1'b1, 0);
      repeat (3) @(posedge clk);
      #1 checkOutput("b2b_stopped", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
